// File: rtl/multi_reset_filter_if.sv
// multi_reset_filter_if: request/clear inputs and conditioned reset outputs.
// master drives rst_req_i/clr_glitch_i; slave (the filter) drives the rest.
interface multi_reset_filter_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0] rst_req_i;
  logic            clr_glitch_i;
  logic [N_CH-1:0] rst_o;
  logic            any_rst_o;
  logic [N_CH-1:0] glitch_o;

  modport master (
    output rst_req_i, clr_glitch_i,
    input  rst_o, any_rst_o, glitch_o
  );

  modport slave (
    input  rst_req_i, clr_glitch_i,
    output rst_o, any_rst_o, glitch_o
  );
endinterface

// File: rtl/multi_reset_filter.sv
// multi_reset_filter: per-channel reset sync, glitch reject, stretch, debounce.
// Ports: clk, rst_i (sync, active-high), bus (slave: req/clr in, rst/any/glitch out).
module multi_reset_filter #(
  parameter int   N_CH         = 4,
  parameter int   SYNC_STAGES  = 2,
  parameter int   MIN_ASSERT   = 4,
  parameter int   MIN_DEASSERT = 4,
  parameter int   HOLD_CYC     = 8,
  parameter logic RST_POL      = 1'b0
) (
  input logic                 clk,
  input logic                 rst_i,
  multi_reset_filter_if.slave bus
);

  localparam int MAX_AB = (MIN_ASSERT > MIN_DEASSERT) ?
                          MIN_ASSERT : MIN_DEASSERT;
  localparam int MAX_C  = (MAX_AB > HOLD_CYC) ? MAX_AB : HOLD_CYC;
  localparam int CW     = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] QA_LAST = CW'(MIN_ASSERT - 1);
  localparam logic [CW-1:0] DA_LAST = CW'(MIN_DEASSERT - 1);
  localparam logic [CW-1:0] HD_LAST = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] C_ZERO  = '0;
  localparam logic [CW-1:0] C_ONE   = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    QUAL,
    HOLD,
    RELEASE
  } state_t;

  logic [SYNC_STAGES-1:0] sync [N_CH];
  state_t                 st    [N_CH];
  state_t                 st_n  [N_CH];
  logic [CW-1:0]          cnt   [N_CH];
  logic [CW-1:0]          cnt_n [N_CH];
  logic [N_CH-1:0]        act;
  logic [N_CH-1:0]        asrt_n;
  logic [N_CH-1:0]        gl_set;

  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      act[c] = (sync[c][SYNC_STAGES-1] == RST_POL);
    end
  end

  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      st_n[c]   = st[c];
      cnt_n[c]  = cnt[c];
      gl_set[c] = 1'b0;
      unique case (st[c])
        IDLE: begin
          if (act[c]) begin
            if (MIN_ASSERT == 1) begin
              st_n[c]  = HOLD;
              cnt_n[c] = C_ZERO;
            end else begin
              st_n[c]  = QUAL;
              cnt_n[c] = C_ONE;
            end
          end
        end
        QUAL: begin
          if (!act[c]) begin
            st_n[c]   = IDLE;
            cnt_n[c]  = C_ZERO;
            gl_set[c] = 1'b1;
          end else if (cnt[c] == QA_LAST) begin
            st_n[c]  = HOLD;
            cnt_n[c] = C_ZERO;
          end else begin
            cnt_n[c] = cnt[c] + C_ONE;
          end
        end
        HOLD: begin
          if (cnt[c] == HD_LAST) begin
            st_n[c]  = RELEASE;
            cnt_n[c] = C_ZERO;
          end else begin
            cnt_n[c] = cnt[c] + C_ONE;
          end
        end
        RELEASE: begin
          // any active sample restarts the release debounce
          if (act[c]) begin
            cnt_n[c] = C_ZERO;
          end else if (cnt[c] == DA_LAST) begin
            st_n[c]  = IDLE;
            cnt_n[c] = C_ZERO;
          end else begin
            cnt_n[c] = cnt[c] + C_ONE;
          end
        end
        default: begin
          st_n[c]  = HOLD;
          cnt_n[c] = C_ZERO;
        end
      endcase
      asrt_n[c] = (st_n[c] == HOLD) || (st_n[c] == RELEASE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      for (int c = 0; c < N_CH; c++) begin
        sync[c] <= {SYNC_STAGES{~RST_POL}};
        st[c]   <= HOLD;
        cnt[c]  <= C_ZERO;
      end
      bus.rst_o     <= {N_CH{RST_POL}};
      bus.any_rst_o <= 1'b1;
      bus.glitch_o  <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        sync[c] <= {sync[c][SYNC_STAGES-2:0], bus.rst_req_i[c]};
        st[c]   <= st_n[c];
        cnt[c]  <= cnt_n[c];
      end
      // outputs follow next state so rst_o and any_rst_o stay aligned
      bus.rst_o     <= RST_POL ? asrt_n : ~asrt_n;
      bus.any_rst_o <= |asrt_n;
      // a new glitch in the clearing cycle survives the clear
      bus.glitch_o  <= (bus.glitch_o & {N_CH{~bus.clr_glitch_i}})
                     | gl_set;
    end
  end

endmodule
